strm_upsizer: RTL

- Stream width upsizer between a narrow stream source (for example, a 32-bit stream with eof) and the 64-bit stream-to-memory DMA write channel.
- Packs Ratio consecutive input words into one output word, lowest lane first (little-endian).
- An eof on a partial group flushes that group immediately, so a frame never merges into the next one.
- Output is registered with a valid/ready handshake and sustains full throughput when the consumer is always ready.

---
 rtl/strm_upsizer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/strm_upsizer.sv
// strm_upsizer: packs Ratio narrow stream words into one wide registered word.
// Optional dout_keep lane mask is enabled by defining STRM_UPSIZE_KEEP_EN.
module strm_upsizer #(
  parameter int InBits    = 32,
  parameter int Ratio     = 2,
  parameter int CountBits = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [InBits-1:0]       din_data,
  input  logic                    din_eof,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [InBits*Ratio-1:0] dout_data,
  output logic                    dout_eof,
`ifdef STRM_UPSIZE_KEEP_EN
  output logic [Ratio-1:0]        dout_keep,
`endif
  output logic [CountBits-1:0]    frame_count
);

  localparam int CntW    = $clog2(Ratio);
  localparam int OutBits = InBits * Ratio;
  localparam int AccBits = (Ratio - 1) * InBits;

  logic                 r_run;
  logic [CntW-1:0]      r_cnt;
  logic [AccBits-1:0]   r_acc;
  logic [OutBits-1:0]   r_data;
  logic                 r_valid;
  logic                 r_eof;
  logic [CountBits-1:0] r_fcnt;

  logic                 w_beat;
  logic                 w_last;
  logic                 w_flush;
  logic                 w_drain;
  logic [OutBits-1:0]   w_accx;
  logic [OutBits-1:0]   w_load;

  assign din_ready = r_run && (!r_valid || dout_ready);
  assign w_beat    = din_valid && din_ready;
  assign w_last    = (r_cnt == CntW'(Ratio - 1));
  assign w_flush   = w_beat && (w_last || din_eof);
  assign w_drain   = r_valid && dout_ready;
  assign w_accx    = {{InBits{1'b0}}, r_acc};

  // Wide word: accumulated lanes below cnt, new word in lane cnt, zeros above.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < Ratio; k++) begin
      if (CntW'(k) == r_cnt)
        w_load[k*InBits +: InBits] = din_data;
      else if (CntW'(k) < r_cnt)
        w_load[k*InBits +: InBits] = w_accx[k*InBits +: InBits];
    end
  end

  // Input side opens only after the first edge following reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_run <= 1'b0;
    else      r_run <= 1'b1;
  end

  // Lane counter and accumulator; both restart after every flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_flush) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_beat) begin
      r_acc[r_cnt*InBits +: InBits] <= din_data;
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Output register: a load wins over a drain so words can go back to back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_eof   <= 1'b0;
    end else if (w_flush) begin
      r_valid <= 1'b1;
      r_data  <= w_load;
      r_eof   <= din_eof;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

`ifdef STRM_UPSIZE_KEEP_EN
  logic [Ratio-1:0] r_keep;
  logic [Ratio-1:0] w_keep;

  // Lanes 0..cnt are populated by the flushing beat.
  always_comb begin
    w_keep = '0;
    for (int k = 0; k < Ratio; k++)
      w_keep[k] = (CntW'(k) <= r_cnt);
  end

  // Keep mask travels with the output word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_keep <= '0;
    else if (w_flush) r_keep <= w_keep;
  end

  assign dout_keep = r_keep;
`endif

  // Count frames as their final word leaves; wraps freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_fcnt <= '0;
    else if (w_drain && r_eof) r_fcnt <= r_fcnt + CountBits'(1);
  end

  assign dout_valid  = r_valid;
  assign dout_data   = r_data;
  assign dout_eof    = r_eof;
  assign frame_count = r_fcnt;

endmodule
